// File: rtl/log2_fx.sv
// Sequential fixed-point log2: priority-encode the integer part, then
// produce fraction bits MSB first by repeated squaring of the mantissa.
// Ports:
//   clk      - rising-edge clock
//   reset    - async active-low reset
//   h        - start request, sampled only while idle
//   in       - unsigned operand, captured on the accepting edge
//   out      - log2(in) as INT_W.FRAC_W unsigned fixed point
//   flag     - one-cycle result-valid pulse
//   busy     - high whenever not idle
//   zero_err - operand was zero, qualified by flag
module log2_fx #(
  parameter  int IN_W    = 8,
  parameter  int FRAC_W  = 5,
  parameter  int GUARD_W = 4,
  localparam int INT_W   = ($clog2(IN_W) < 1) ? 1 : $clog2(IN_W),
  localparam int OUT_W   = INT_W + FRAC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              h,
  input  logic [IN_W-1:0]   in,
  output logic [OUT_W-1:0]  out,
  output logic              flag,
  output logic              busy,
  output logic              zero_err
);

  // mantissa is 1.f with MF fraction bits
  localparam int MF    = IN_W - 1 + GUARD_W;
  localparam int MW    = MF + 1;
  localparam int CNT_W = $clog2(FRAC_W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] NORM = 2'd1;
  localparam logic [1:0] SQR  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [IN_W-1:0]  opnd;
  logic [MW-1:0]    m;
  logic [CNT_W-1:0] cnt;
  logic [INT_W-1:0] int_r;
  logic [FRAC_W-1:0] frac_r;
  logic             zero_r;
  logic [OUT_W-1:0] out_r;

  logic [INT_W-1:0] msb;
  logic [INT_W-1:0] shamt;
  logic [IN_W-1:0]  norm;
  logic [2*MW-1:0]  mx;
  logic [2*MW-1:0]  prod;
  logic [MW:0]      sq;
  logic             bit_nx;
  logic [MW-1:0]    m_nx;
  logic [FRAC_W-1:0] frac_nx;
  logic             last;

  always_comb begin
    msb = '0;
    for (int i = 0; i < IN_W; i++)
      if (opnd[i]) msb = INT_W'(i);
  end

  assign shamt = INT_W'(IN_W - 1) - msb;
  assign norm  = opnd << shamt;

  // square keeps only MF fraction bits; sq holds values in [1,4)
  assign mx   = {{MW{1'b0}}, m};
  assign prod = mx * mx;
  assign sq   = (MW+1)'(prod >> MF);

  assign bit_nx  = sq[MW];
  assign m_nx    = bit_nx ? sq[MW:1] : sq[MW-1:0];
  assign frac_nx = FRAC_W'({frac_r, bit_nx});
  assign last    = (cnt == CNT_W'(FRAC_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      opnd   <= '0;
      m      <= '0;
      cnt    <= '0;
      int_r  <= '0;
      frac_r <= '0;
      zero_r <= 1'b0;
      out_r  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (h) begin
            opnd  <= in;
            state <= NORM;
          end
        end
        NORM: begin
          cnt    <= '0;
          frac_r <= '0;
          if (opnd == '0) begin
            zero_r <= 1'b1;
            out_r  <= '0;
            state  <= DONE;
          end else begin
            zero_r <= 1'b0;
            int_r  <= msb;
            m      <= MW'(norm) << GUARD_W;
            state  <= SQR;
          end
        end
        SQR: begin
          m      <= m_nx;
          frac_r <= frac_nx;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            out_r <= {int_r, frac_nx};
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign out      = out_r;
  assign flag     = (state == DONE);
  assign busy     = (state != IDLE);
  assign zero_err = flag & zero_r;

endmodule
